// File: rtl/io_slow_out_seq.sv
// rtl/io_slow_out_seq.sv - slow-output character sequencer; optional parity bit via G15_OUT_PARITY_EN
module io_slow_out_seq #(
    parameter int CHARS_PER_WORD = 7,
    parameter int ACK_TIMEOUT    = 4096,
    parameter int GAP_CYCLES     = 3
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       T0,
    input  logic       OZ,
    input  logic       SLOW_OUT,
    input  logic       MZ,
    input  logic [2:0] FMT,
    input  logic       DEV_ACK,
    output logic       DEV_REQ,
    output logic [6:0] DEV_CODE,
    output logic       DIGIT_OF,
    output logic       WAIT_OF,
    output logic       CR_TAB_OF,
    output logic       OUT_DONE,
    output logic       SEQ_READY,
    output logic       SEQ_ERR
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CW = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;

    localparam logic [1:0] CLS_DIGIT = 2'b00;
    localparam logic [1:0] CLS_CRTAB = 2'b01;
    localparam logic [1:0] CLS_WAIT  = 2'b10;
    localparam logic [1:0] CLS_END   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_ASSEMBLE, S_PRESENT, S_WAIT_ACK, S_GAP
    } state_t;

    state_t        state, state_nx;
    logic          slow_d;
    logic [2:0]    fmt_r;
    logic [3:0]    oa;
    logic [1:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic [CW-1:0] char_cnt;
    logic [1:0]    cls_r;
    logic          par;
    logic          slow_rise;
    logic          abort;
    logic          ack_take;
    logic          tmo_hit;
    logic          gap_done;
    logic          last_in_word;

    function automatic logic [1:0] fmt_class(input logic [2:0] f);
        case (f)
            3'b010, 3'b110: fmt_class = CLS_CRTAB;
            3'b111:         fmt_class = CLS_WAIT;
            3'b001:         fmt_class = CLS_END;
            default:        fmt_class = CLS_DIGIT;
        endcase
    endfunction

    assign cls_r        = fmt_class(fmt_r);
    assign slow_rise    = SLOW_OUT & ~slow_d;
    assign abort        = (state != S_IDLE) && !SLOW_OUT;
    assign last_in_word = (char_cnt == CW'(CHARS_PER_WORD - 1));
    assign SEQ_READY    = (state == S_IDLE);

`ifdef G15_OUT_PARITY_EN
    assign par = ~^{cls_r, oa};
`else
    assign par = 1'b0;
`endif

    // State register
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; dropping SLOW_OUT overrides every other event
    always_comb begin
        state_nx = state;
        ack_take = 1'b0;
        tmo_hit  = 1'b0;
        gap_done = 1'b0;
        case (state)
            S_IDLE: begin
                // after a timeout, only a fresh SLOW_OUT rise restarts the sequencer
                if (SLOW_OUT && (!SEQ_ERR || slow_rise)) state_nx = S_SYNC;
            end
            S_SYNC: begin
                // T0 never overlaps the OZ window; a T0 inside it is a glitch
                if (T0 && !OZ) state_nx = S_ASSEMBLE;
            end
            S_ASSEMBLE: begin
                if (bit_cnt == 2'd3) state_nx = S_PRESENT;
            end
            S_PRESENT: begin
                state_nx = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (DEV_ACK) begin
                    ack_take = 1'b1;
                    state_nx = S_GAP;
                end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    tmo_hit  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    gap_done = 1'b1;
                    if (cls_r == CLS_END)  state_nx = S_IDLE;
                    else if (last_in_word) state_nx = S_SYNC;
                    else                   state_nx = S_ASSEMBLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
            ack_take = 1'b0;
            tmo_hit  = 1'b0;
            gap_done = 1'b0;
        end
    end

    // Datapath: digit assembly, handshake, counters, strobes and sticky error
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            slow_d    <= 1'b0;
            fmt_r     <= 3'd0;
            oa        <= 4'd0;
            bit_cnt   <= 2'd0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            char_cnt  <= '0;
            DEV_REQ   <= 1'b0;
            DEV_CODE  <= 7'd0;
            DIGIT_OF  <= 1'b0;
            WAIT_OF   <= 1'b0;
            CR_TAB_OF <= 1'b0;
            OUT_DONE  <= 1'b0;
            SEQ_ERR   <= 1'b0;
        end else begin
            slow_d    <= SLOW_OUT;
            DIGIT_OF  <= 1'b0;
            WAIT_OF   <= 1'b0;
            CR_TAB_OF <= 1'b0;
            OUT_DONE  <= 1'b0;
            if (slow_rise) SEQ_ERR <= 1'b0;
            if (abort) begin
                DEV_REQ  <= 1'b0;
                char_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: char_cnt <= '0;
                    S_SYNC: begin
                        if (T0 && !OZ) begin
                            bit_cnt <= 2'd0;
                            fmt_r   <= FMT;
                        end
                    end
                    S_ASSEMBLE: begin
                        oa[bit_cnt] <= MZ;
                        bit_cnt     <= bit_cnt + 2'd1;
                    end
                    S_PRESENT: begin
                        DEV_CODE <= {par, cls_r, oa};
                        DEV_REQ  <= 1'b1;
                        tmo_cnt  <= '0;
                    end
                    S_WAIT_ACK: begin
                        if (ack_take) begin
                            DEV_REQ   <= 1'b0;
                            gap_cnt   <= '0;
                            DIGIT_OF  <= (cls_r == CLS_DIGIT);
                            WAIT_OF   <= (cls_r == CLS_WAIT);
                            CR_TAB_OF <= (cls_r == CLS_CRTAB);
                        end else if (tmo_hit) begin
                            DEV_REQ <= 1'b0;
                            SEQ_ERR <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    S_GAP: begin
                        if (gap_done) begin
                            if (cls_r == CLS_END) begin
                                OUT_DONE <= 1'b1;
                            end else if (last_in_word) begin
                                char_cnt <= '0;
                            end else begin
                                char_cnt <= char_cnt + CW'(1);
                                bit_cnt  <= 2'd0;
                                fmt_r    <= FMT;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_io_slow_out_seq.sv
// tb/tb_io_slow_out_seq.sv - self-checking bench for io_slow_out_seq (parity expectations follow G15_OUT_PARITY_EN)
module tb_io_slow_out_seq;
    localparam int CPW = 7;
    localparam int ATO = 16;
    localparam int GAP = 3;
    localparam int N   = 4000;
    localparam int NA  = N + 800;

    logic       CLOCK = 1'b0;
    logic       rst, T0, OZ, SLOW_OUT, MZ, DEV_ACK;
    logic [2:0] FMT;
    logic       DEV_REQ, DIGIT_OF, WAIT_OF, CR_TAB_OF, OUT_DONE, SEQ_READY, SEQ_ERR;
    logic [6:0] DEV_CODE;

    int checks   = 0;
    int failures = 0;

    io_slow_out_seq #(.CHARS_PER_WORD(CPW), .ACK_TIMEOUT(ATO), .GAP_CYCLES(GAP)) dut (
        .CLOCK(CLOCK), .rst(rst), .T0(T0), .OZ(OZ), .SLOW_OUT(SLOW_OUT), .MZ(MZ),
        .FMT(FMT), .DEV_ACK(DEV_ACK), .DEV_REQ(DEV_REQ), .DEV_CODE(DEV_CODE),
        .DIGIT_OF(DIGIT_OF), .WAIT_OF(WAIT_OF), .CR_TAB_OF(CR_TAB_OF),
        .OUT_DONE(OUT_DONE), .SEQ_READY(SEQ_READY), .SEQ_ERR(SEQ_ERR)
    );

    // Free-running clock
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [2:0] fmt;
        logic [3:0] dig;
        int         d;
        logic [5:0] code6;
        logic [2:0] stb;
        logic       done;
    } vec_t;

    vec_t vecs [8];

    logic       in_slow [0:NA];
    logic       in_t0   [0:NA];
    logic       in_oz   [0:NA];
    logic       in_mz   [0:NA];
    logic       in_ack  [0:NA];
    logic [2:0] in_fmt  [0:NA];
    logic       exp_req [0:NA];
    logic [2:0] exp_stb [0:NA];
    logic       exp_done[0:NA];
    logic       exp_rdy [0:NA];
    logic       ld      [0:NA];
    logic [6:0] ld_code [0:NA];
    logic [6:0] exp_code[0:NA];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic [2:0] stb();
        return {DIGIT_OF, WAIT_OF, CR_TAB_OF};
    endfunction

    function automatic logic [6:0] mk_code(input logic [1:0] cls, input logic [3:0] dg);
`ifdef G15_OUT_PARITY_EN
        return {~^{cls, dg}, cls, dg};
`else
        return {1'b0, cls, dg};
`endif
    endfunction

    function automatic logic [1:0] ref_class(input logic [2:0] f);
        if (f == 3'b010 || f == 3'b110) return 2'b01;
        if (f == 3'b111) return 2'b10;
        if (f == 3'b001) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] ref_stb(input logic [1:0] cls);
        case (cls)
            2'b00:   return 3'b100;
            2'b10:   return 3'b010;
            2'b01:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // One character from its start edge up to (not including) the last GAP edge
    task automatic run_char(input logic [2:0] f, input logic [3:0] dg, input int d,
                            output logic [6:0] code, output int rq, output logic req_after,
                            output logic [2:0] stb_ack, output logic [2:0] stb_after);
        FMT = f;
        step();
        T0 = 1'b0;
        FMT = 3'($urandom);
        for (int i = 0; i < 4; i++) begin
            MZ = dg[i];
            step();
        end
        MZ = 1'($urandom);
        step();
        code = DEV_CODE;
        rq = 0;
        for (int i = 0; i < d; i++) begin
            rq += int'(DEV_REQ);
            step();
        end
        rq += int'(DEV_REQ);
        DEV_ACK = 1'b1;
        step();
        stb_ack   = stb();
        req_after = DEV_REQ;
        DEV_ACK = 1'b0;
        step();
        stb_after = stb();
        for (int i = 0; i < GAP - 2; i++) step();
    endtask

    task automatic do_timeout(output int rq, output logic [2:0] sany);
        SLOW_OUT = 1'b1; T0 = 1'b0; DEV_ACK = 1'b0;
        step();
        T0 = 1'b1; FMT = 3'b000;
        step();
        T0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MZ = 1'($urandom);
            step();
        end
        step();
        rq = 0;
        sany = 3'b000;
        for (int i = 0; i < 40; i++) begin
            rq += int'(DEV_REQ);
            sany |= stb();
            step();
        end
    endtask

    // Directed vectors, hand-written corner sequences, then a randomized timeline against the model
    initial begin
        logic [6:0] code;
        int         rq, pulses, t, s, a, g, d, cc, nchar, bstart, endk, sync_from;
        logic       ra, done_sess, rdy_any;
        logic [2:0] sa, sb, f;
        logic [1:0] cls;
        logic [3:0] dg;
        logic [6:0] cur;

        vecs[0] = '{3'b000, 4'b0101, 5, 6'b00_0101, 3'b100, 1'b0};
        vecs[1] = '{3'b010, 4'b1100, 0, 6'b01_1100, 3'b001, 1'b0};
        vecs[2] = '{3'b110, 4'b0011, 2, 6'b01_0011, 3'b001, 1'b0};
        vecs[3] = '{3'b111, 4'b1001, 1, 6'b10_1001, 3'b010, 1'b0};
        vecs[4] = '{3'b001, 4'b0111, 3, 6'b11_0111, 3'b000, 1'b1};
        vecs[5] = '{3'b011, 4'b1111, 0, 6'b00_1111, 3'b100, 1'b0};
        vecs[6] = '{3'b100, 4'b1000, 1, 6'b00_1000, 3'b100, 1'b0};
        vecs[7] = '{3'b101, 4'b0000, 0, 6'b00_0000, 3'b100, 1'b0};

        rst = 1'b0; T0 = 1'b0; OZ = 1'b0; SLOW_OUT = 1'b0; MZ = 1'b0; FMT = 3'd0; DEV_ACK = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("reset_state", {DEV_REQ, stb(), OUT_DONE, SEQ_READY, SEQ_ERR, DEV_CODE},
              {1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 7'd0});
        rst = 1'b1;
        step();

        foreach (vecs[i]) begin
            SLOW_OUT = 1'b1; T0 = 1'b0;
            step();
            check($sformatf("v%0d_busy", i), SEQ_READY, 1'b0);
            T0 = 1'b1;
            run_char(vecs[i].fmt, vecs[i].dig, vecs[i].d, code, rq, ra, sa, sb);
            check($sformatf("v%0d_code", i), code, mk_code(vecs[i].code6[5:4], vecs[i].code6[3:0]));
            check($sformatf("v%0d_req_cycles", i), rq, vecs[i].d + 1);
            check($sformatf("v%0d_req_drop", i), ra, 1'b0);
            check($sformatf("v%0d_strobe", i), sa, vecs[i].stb);
            check($sformatf("v%0d_strobe_once", i), sb, 3'b000);
            step();
            check($sformatf("v%0d_done", i), OUT_DONE, vecs[i].done);
            SLOW_OUT = 1'b0;
            step();
            check($sformatf("v%0d_idle", i), SEQ_READY, 1'b1);
        end

        SLOW_OUT = 1'b1; T0 = 1'b0;
        step();
        T0 = 1'b1;
        run_char(3'b010, 4'b0001, 0, code, rq, ra, sa, sb);
        check("seq_cr", {sa, sb}, {3'b001, 3'b000});
        run_char(3'b111, 4'b0010, 1, code, rq, ra, sa, sb);
        check("seq_wait", {sa, sb}, {3'b010, 3'b000});
        run_char(3'b001, 4'b0011, 0, code, rq, ra, sa, sb);
        check("seq_end_no_strobe", sa, 3'b000);
        step();
        check("seq_done", {OUT_DONE, SEQ_READY}, 2'b11);
        SLOW_OUT = 1'b0;
        step();
        check("seq_done_once", OUT_DONE, 1'b0);

        SLOW_OUT = 1'b1; T0 = 1'b0;
        step();
        T0 = 1'b1;
        pulses = 0;
        for (int i = 0; i < CPW; i++) begin
            run_char(3'b000, 4'($urandom), 0, code, rq, ra, sa, sb);
            pulses += int'(sa == 3'b100);
        end
        rq = 0; rdy_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            rq += int'(DEV_REQ);
            rdy_any |= SEQ_READY;
        end
        check("word_digit_pulses", pulses, CPW);
        check("word_resync_no_req", rq, 0);
        check("word_resync_busy", rdy_any, 1'b0);
        T0 = 1'b1;
        run_char(3'b000, 4'b1010, 0, code, rq, ra, sa, sb);
        check("word_next_code", code, mk_code(2'b00, 4'b1010));
        check("word_next_strobe", sa, 3'b100);
        step();
        SLOW_OUT = 1'b0;
        step();

        do_timeout(rq, sa);
        check("tmo_req_cycles", rq, ATO);
        check("tmo_no_strobe", sa, 3'b000);
        check("tmo_err", SEQ_ERR, 1'b1);
        SLOW_OUT = 1'b0;
        step();
        check("tmo_err_sticky", SEQ_ERR, 1'b1);
        SLOW_OUT = 1'b1;
        step();
        check("tmo_err_clear_on_rise", SEQ_ERR, 1'b0);
        T0 = 1'b1;
        run_char(3'b000, 4'b0110, ATO - 1, code, rq, ra, sa, sb);
        check("tmo_edge_ack_wins", {sa, SEQ_ERR}, {3'b100, 1'b0});
        check("tmo_edge_req_cycles", rq, ATO);
        step();
        SLOW_OUT = 1'b0;
        step();
        do_timeout(rq, sa);
        check("tmo2_err", SEQ_ERR, 1'b1);
        rst = 1'b0;
        step();
        check("reset_clears_err", SEQ_ERR, 1'b0);
        SLOW_OUT = 1'b0; rst = 1'b1;
        step();

        SLOW_OUT = 1'b1; T0 = 1'b0;
        step();
        T0 = 1'b1; FMT = 3'b000;
        step();
        T0 = 1'b0; MZ = 1'b1;
        for (int i = 0; i < 5; i++) step();
        step(); step();
        check("abort_req_before", DEV_REQ, 1'b1);
        SLOW_OUT = 1'b0; DEV_ACK = 1'b1;
        step();
        check("abort_vs_ack", {DEV_REQ, stb(), SEQ_READY}, {1'b0, 3'b000, 1'b1});
        DEV_ACK = 1'b0;
        step();
        check("abort_no_late_strobe", stb(), 3'b000);

        SLOW_OUT = 1'b1; T0 = 1'b0;
        step();
        T0 = 1'b1; FMT = 3'b111;
        step();
        T0 = 1'b0; MZ = 1'b1;
        for (int i = 0; i < 5; i++) step();
        step(); step();
        check("rst_mid_code_before", {DEV_REQ, DEV_CODE}, {1'b1, mk_code(2'b10, 4'b1111)});
        rst = 1'b0;
        step();
        check("rst_mid_handshake", {DEV_REQ, SEQ_READY, SEQ_ERR, DEV_CODE}, {1'b0, 1'b1, 1'b0, 7'd0});
        step(); step();
        SLOW_OUT = 1'b0; rst = 1'b1;
        step();

        for (int k = 0; k <= NA; k++) begin
            in_slow[k] = 1'b0;
            in_t0[k]   = (k % 32 == 0);
            in_oz[k]   = (k % 32 >= 1) && (k % 32 <= 29) && ((k / 32) % 4 == 0);
            in_mz[k]   = 1'($urandom);
            in_fmt[k]  = 3'($urandom);
            in_ack[k]  = ($urandom_range(0, 3) == 0);
            exp_req[k] = 1'b0; exp_stb[k] = 3'b000; exp_done[k] = 1'b0; exp_rdy[k] = 1'b1;
            ld[k] = 1'b0; ld_code[k] = 7'd0;
        end
        t = 5;
        while (t < N - 600) begin
            bstart = t; sync_from = t; s = -1; cc = 0; nchar = 0; done_sess = 1'b0; endk = t;
            while (!done_sess) begin
                if (s < 0) begin
                    s = sync_from + 1;
                    while (!in_t0[s]) s++;
                end
                f = (nchar == 11) ? 3'b001 : 3'($urandom);
                in_fmt[s] = f;
                cls = ref_class(f);
                dg = {in_mz[s+4], in_mz[s+3], in_mz[s+2], in_mz[s+1]};
                ld[s+5] = 1'b1;
                ld_code[s+5] = mk_code(cls, dg);
                d = $urandom_range(0, 6);
                a = s + 6 + d;
                for (int j = s + 5; j < a; j++) exp_req[j] = 1'b1;
                for (int j = s + 6; j < a; j++) in_ack[j] = 1'b0;
                in_ack[a] = 1'b1;
                exp_stb[a] = ref_stb(cls);
                g = a + GAP;
                nchar++;
                if (cls == 2'b11) begin
                    exp_done[g] = 1'b1;
                    endk = g;
                    done_sess = 1'b1;
                end else begin
                    cc++;
                    if (cc == CPW) begin
                        cc = 0; sync_from = g; s = -1;
                    end else begin
                        s = g;
                    end
                end
            end
            for (int j = bstart; j < endk; j++) exp_rdy[j] = 1'b0;
            for (int j = bstart; j <= endk; j++) in_slow[j] = 1'b1;
            t = endk + 1 + $urandom_range(1, 6);
        end
        cur = 7'd0;
        for (int k = 0; k <= NA; k++) begin
            if (ld[k]) cur = ld_code[k];
            exp_code[k] = cur;
        end

        rst = 1'b0; SLOW_OUT = 1'b0; DEV_ACK = 1'b0; T0 = 1'b0; OZ = 1'b0;
        step(); step();
        rst = 1'b1;
        for (int k = 1; k <= N; k++) begin
            SLOW_OUT = in_slow[k]; T0 = in_t0[k]; OZ = in_oz[k]; MZ = in_mz[k];
            FMT = in_fmt[k]; DEV_ACK = in_ack[k];
            step();
            check($sformatf("rand@%0d", k),
                  {DEV_REQ, stb(), OUT_DONE, SEQ_READY, SEQ_ERR, DEV_CODE},
                  {exp_req[k], exp_stb[k], exp_done[k], exp_rdy[k], 1'b0, exp_code[k]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_slow_out_seq.md
Name: io_slow_out_seq

Overview:
- Sequencer for slow-output (typewriter/punch) I/O.
- Waits for word-0 timing (OZ), assembles 4-bit digits shifted out of MZ, and decodes a per-character 3-bit format code.
- Presents each character to the external device over a req/ack handshake.
- Produces the one-clock DIGIT_OF / WAIT_OF / CR_TAB_OF strobes consumed by the I/O 11 / MZ logic, plus a device-ready and error status.

Parameters:
- CHARS_PER_WORD, 7, digit characters taken per drum word before resyncing to the next word 0 (range 1..7).
- ACK_TIMEOUT, 4096, CLOCKs allowed between DEV_REQ assertion and DEV_ACK before error abort (>=2).
- GAP_CYCLES, 3, idle CLOCKs after ACK before the next character (>=1).

Ports:
- CLOCK  in  1  system clock; one CLOCK = one drum bit time.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on CLOCK rising edge).
- T0  in  1  bit-time 0 of every word.
- OZ  in  1  word-0 window, T1..T29.
- SLOW_OUT  in  1  slow output operation active.
- MZ  in  1  MZ line data, LSB first.
- FMT  in  3  format code for the current character, valid while ASSEMBLE starts.
- DEV_ACK  in  1  device accepted the character (level).
- DEV_REQ  out  1  character valid to device.
- DEV_CODE  out  7  [3:0] digit, [5:4] class (00 digit, 01 CR/tab, 10 wait, 11 end), [6] parity.
- DIGIT_OF  out  1  one-CLOCK pulse after a digit character is acknowledged.
- WAIT_OF  out  1  one-CLOCK pulse after a wait character is acknowledged.
- CR_TAB_OF  out  1  one-CLOCK pulse after a CR or tab character is acknowledged.
- OUT_DONE  out  1  one-CLOCK pulse at an end-code completion.
- SEQ_READY  out  1  high in IDLE.
- SEQ_ERR  out  1  sticky timeout error.

Behaviour:
- Reset (rst=0):
  - State goes to IDLE.
  - All outputs 0 except SEQ_READY=1.
  - DEV_CODE=0, counters=0, SEQ_ERR=0.
  - Reset mid-handshake drops DEV_REQ on the next edge.
- FMT decode:
  - 000 digit.
  - 010 CR, 110 tab → class 01.
  - 111 wait → class 10.
  - 001 end → class 11.
  - Other codes are treated as digit.
- IDLE:
  - SLOW_OUT=1 → SYNC.
  - SEQ_ERR clears only on reset or on a new SLOW_OUT rising edge.
- SYNC:
  - Wait for the cycle with T0=1. On that edge → ASSEMBLE, bit_cnt=0, latch FMT into fmt_r.
- ASSEMBLE:
  - Shift MZ into oa[bit_cnt] for 4 consecutive CLOCKs. Bits are taken from the 4 clocks following the T0 cycle, then contiguous 4-bit groups.
  - After bit_cnt=3 → PRESENT.
- PRESENT:
  - Load DEV_CODE={par, class, oa}.
  - DEV_REQ=1 from the next CLOCK; start timeout counter → WAIT_ACK.
- WAIT_ACK:
  - Hold DEV_REQ and DEV_CODE stable.
  - If DEV_ACK=1: DEV_REQ=0 next CLOCK, pulse the class strobe for exactly 1 CLOCK, → GAP.
  - If the counter reaches ACK_TIMEOUT without DEV_ACK: SEQ_ERR=1, DEV_REQ=0, → IDLE, no strobe.
  - If DEV_ACK is already high when REQ rises, it counts as acknowledged. Latency REQ→strobe is 1 CLOCK.
- GAP:
  - Wait GAP_CYCLES, then:
    - If class is end: pulse OUT_DONE, → IDLE.
    - Else increment char_cnt. If char_cnt==CHARS_PER_WORD: char_cnt=0, → SYNC (next word). Otherwise → ASSEMBLE, latch new FMT.
  - char_cnt counts all classes.
- Abort: SLOW_OUT=0 in any non-IDLE state → IDLE next CLOCK. DEV_REQ drops, no strobe, char_cnt cleared.
- Simultaneous events:
  - SLOW_OUT fall with DEV_ACK: abort wins, no strobe.
  - Timeout and ACK on the same CLOCK: ACK wins.
- Strobes are mutually exclusive and never asserted outside the cycle following ACK.

Optional Feature:
- Macro G15_OUT_PARITY_EN.
- Defined: DEV_CODE[6] = odd parity over DEV_CODE[5:0] (XNOR-reduce).
- Undefined: DEV_CODE[6] tied 0; no parity logic.
- Timing is identical in both cases.

Test Plan:
- Reset with rst=0 for 3 CLOCKs mid-WAIT_ACK → DEV_REQ=0, SEQ_READY=1, SEQ_ERR=0, DEV_CODE=0 on the first edge.
- SLOW_OUT=1, FMT=000, MZ bits 1,0,1,0 after T0, DEV_ACK 5 CLOCKs after REQ → DEV_CODE[5:0]=000101, DIGIT_OF pulses exactly 1 CLOCK after ACK; with the parity macro, DEV_CODE[6]=1.
- FMT=010 then 111 then 001 → CR_TAB_OF, WAIT_OF, OUT_DONE in order, each 1 CLOCK, then SEQ_READY=1.
- CHARS_PER_WORD=7, all digits with instant ACK → 7 DIGIT_OF pulses, then the sequencer idles in SYNC until the next T0 before the 8th.
- ACK_TIMEOUT=16, DEV_ACK held 0 → DEV_REQ drops after 16 CLOCKs, SEQ_ERR=1 sticky, no strobe; a new SLOW_OUT rise clears SEQ_ERR.
- SLOW_OUT dropped on the same CLOCK as DEV_ACK → no DIGIT_OF, DEV_REQ=0 next CLOCK, state IDLE.
